// File: rtl/pic_port_pkg.sv
// ============================================================================
//  Module      : pic_port_pkg
//  Description : Shared defaults and read-mode encodings for the PIC port path
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pic_port_pkg;

    localparam int               DEFAULT_WIDTH    = 8;
    localparam logic [7:0]       DEFAULT_IOC_MASK = 8'hF0;

    // Read value returned for bits configured as outputs
    localparam int               READ_ZERO        = 0;
    localparam int               READ_LATCH       = 1;

endpackage

`default_nettype wire

// File: rtl/port_sync_chain.sv
// ============================================================================
//  Module      : port_sync_chain
//  Description : WIDTH-bit multi-flop synchroniser, synchronous reset to RESET_VAL
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module port_sync_chain #(
    parameter int               WIDTH       = 8,
    parameter int               SYNC_STAGES = 2,     // legal range 2..4
    parameter logic [WIDTH-1:0] RESET_VAL   = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] sync_o
);

    logic [WIDTH-1:0] stage_q [SYNC_STAGES];

    generate
        for (genvar k = 0; k < SYNC_STAGES; k++) begin : g_stage
            if (k == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (rst) stage_q[k] <= RESET_VAL;
                    else     stage_q[k] <= async_i;
                end
            end else begin : g_rest
                always_ff @(posedge clk) begin
                    if (rst) stage_q[k] <= RESET_VAL;
                    else     stage_q[k] <= stage_q[k-1];
                end
            end
        end
    endgenerate

    assign sync_o = stage_q[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/port_input_sync.sv
// ============================================================================
//  Module      : port_input_sync
//  Description : Synchronised, TRIS-masked port read with interrupt-on-change
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module port_input_sync
    import pic_port_pkg::*;
#(
    parameter int               WIDTH         = DEFAULT_WIDTH,
    parameter int               SYNC_STAGES   = 2,
    parameter logic [WIDTH-1:0] IOC_MASK      = WIDTH'(DEFAULT_IOC_MASK),
    parameter int               OUT_READ_MODE = READ_ZERO,
    parameter logic [WIDTH-1:0] RESET_VAL     = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] tris,
    input  logic [WIDTH-1:0] pin_in,
    input  logic [WIDTH-1:0] pin_out,
    input  logic             rd_strobe,
    input  logic             ioc_en,
    input  logic             ioc_flag_clr,
    output logic [WIDTH-1:0] data_in,
    output logic             ioc_flag,
    output logic             int_req
);

    logic [WIDTH-1:0] sync_val;
    logic [WIDTH-1:0] out_val;
    logic             mismatch;

    logic [WIDTH-1:0] data_d,     data_q;
    logic [WIDTH-1:0] snapshot_d, snapshot_q;
    logic             ioc_flag_d, ioc_flag_q;

    port_sync_chain #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (RESET_VAL)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .async_i (pin_in),
        .sync_o  (sync_val)
    );

    always_comb begin
        out_val    = (OUT_READ_MODE == READ_LATCH) ? pin_out : '0;
        data_d     = (tris & sync_val) | (~tris & out_val);
        snapshot_d = rd_strobe ? sync_val : snapshot_q;
        // Compared against the pre-edge snapshot, so a read in the same cycle
        // as a change still lets that change set the flag once.
        mismatch   = |((sync_val ^ snapshot_q) & IOC_MASK & tris);
        ioc_flag_d = ioc_flag_q;
        if (mismatch)          ioc_flag_d = 1'b1;
        else if (ioc_flag_clr) ioc_flag_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q     <= '0;
            snapshot_q <= RESET_VAL;
            ioc_flag_q <= 1'b0;
        end else begin
            data_q     <= data_d;
            snapshot_q <= snapshot_d;
            ioc_flag_q <= ioc_flag_d;
        end
    end

    assign data_in  = data_q;
    assign ioc_flag = ioc_flag_q;
    assign int_req  = ioc_flag_q & ioc_en;

endmodule

`default_nettype wire
